// File: rtl/arb_mux.sv
// Registered N-to-1 arbitrating mux with valid/ready handshakes on every input channel and on the output.
// Optional macro ARB_MUX_FIXED_PRIORITY_EN: lowest valid index always wins and no rotating pointer is kept.
module arb_mux #(
  parameter int P_WIDTH = 4,
  parameter int P_DEPTH = 16
) (
  input  logic                              I_CLK,
  input  logic                              I_RESET,
  input  logic [P_WIDTH-1:0][P_DEPTH-1:0]   I_INPUT,
  input  logic [P_WIDTH-1:0]                I_VALID,
  output logic [P_WIDTH-1:0]                O_READY,
  output logic [P_DEPTH-1:0]                O_OUTPUT,
  output logic [$clog2(P_WIDTH)-1:0]        O_SELECT,
  output logic                              O_VALID,
  input  logic                              I_READY
);

  localparam int SEL_W = $clog2(P_WIDTH);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(P_WIDTH - 1);

  logic                 load_s;
  logic                 grant_found_s;
  logic [SEL_W-1:0]     grant_idx_s;
  logic [P_WIDTH-1:0]   ready_s;
  logic [P_DEPTH-1:0]   out_data_r;
  logic [SEL_W-1:0]     out_sel_r;
  logic                 out_valid_r;

  // The output register can accept a word when it is empty or being drained this cycle.
  assign load_s        = !out_valid_r || I_READY;
  assign grant_found_s = |I_VALID;

`ifdef ARB_MUX_FIXED_PRIORITY_EN

  // Fixed priority: scan downward so the lowest valid index is the last (winning) assignment.
  always_comb begin
    grant_idx_s = '0;
    for (int i = P_WIDTH - 1; i >= 0; i--) begin
      grant_idx_s = I_VALID[i] ? SEL_W'(i) : grant_idx_s;
    end
  end

`else

  localparam logic [SEL_W:0] WIDTH_EXT = (SEL_W + 1)'(P_WIDTH);

  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W:0]   cand_ext_s;
  logic [SEL_W-1:0] cand_s;

  // Round-robin scan from ptr_r; offsets are visited high to low so the nearest valid channel wins.
  always_comb begin
    grant_idx_s = '0;
    cand_ext_s  = '0;
    cand_s      = '0;
    for (int i = P_WIDTH - 1; i >= 0; i--) begin
      cand_ext_s  = {1'b0, ptr_r} + (SEL_W + 1)'(i);
      cand_s      = (cand_ext_s >= WIDTH_EXT) ? SEL_W'(cand_ext_s - WIDTH_EXT)
                                              : cand_ext_s[SEL_W-1:0];
      grant_idx_s = I_VALID[cand_s] ? cand_s : grant_idx_s;
    end
  end

  // Pointer moves just past the granted channel, wrapping at the last index.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      ptr_r <= '0;
    end else if (load_s && grant_found_s) begin
      ptr_r <= (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + SEL_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

`endif

  // One-hot accept toward the granted producer; silenced during reset and stalls.
  always_comb begin
    ready_s = '0;
    if (!I_RESET && load_s && grant_found_s) begin
      ready_s[grant_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Output register: load on grant, empty on idle load, hold on stall.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
    end else if (load_s) begin
      if (grant_found_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= I_INPUT[grant_idx_s];
        out_sel_r   <= grant_idx_s;
      end else begin
        out_valid_r <= 1'b0;
        out_data_r  <= out_data_r;
        out_sel_r   <= out_sel_r;
      end
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_sel_r   <= out_sel_r;
    end
  end

  assign O_READY  = ready_s;
  assign O_OUTPUT = out_data_r;
  assign O_SELECT = out_sel_r;
  assign O_VALID  = out_valid_r;

endmodule

// File: tb/tb_arb_mux.sv
// Table-driven bench for arb_mux (round-robin build, 4 channels x 8 bits) with a scoreboard of granted words.
module tb_arb_mux;

  localparam int W = 4;
  localparam int D = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [W-1:0][D-1:0]  din;
  logic [W-1:0]         vld;
  logic [W-1:0]         ordy;
  logic [D-1:0]         dout;
  logic [1:0]           sel;
  logic                 ov;
  logic                 rdy;

  always #5 clk = ~clk;

  arb_mux #(.P_WIDTH(W), .P_DEPTH(D)) dut (
    .I_CLK(clk), .I_RESET(reset), .I_INPUT(din), .I_VALID(vld), .O_READY(ordy),
    .O_OUTPUT(dout), .O_SELECT(sel), .O_VALID(ov), .I_READY(rdy)
  );

  typedef struct {
    logic                rst;
    logic [W-1:0]        vld;
    logic                rdy;
    logic [W-1:0][D-1:0] d;
    logic [W-1:0]        e_rdy;
    logic                e_ov;
  } vec_t;

  typedef struct {
    logic [D-1:0] d;
    logic [1:0]   s;
  } exp_t;

  exp_t         sb_q[$];
  vec_t         tbl[$];
  logic [D-1:0] exp_word;
  logic [1:0]   exp_sel;
  int           n_vec = 0;
  int           n_err = 0;

  // Channel g carries 8'h10+g, except channel 2 which takes d2.
  function automatic vec_t mk(logic r, logic [3:0] v, logic rd, logic [7:0] d2,
                              logic [3:0] er, logic eov);
    vec_t t;
    t.rst = r; t.vld = v; t.rdy = rd;
    t.d[0] = 8'h10; t.d[1] = 8'h11; t.d[2] = d2; t.d[3] = 8'h13;
    t.e_rdy = er; t.e_ov = eov;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    int   ch;
    @(negedge clk);
    reset = v.rst; vld = v.vld; rdy = v.rdy; din = v.d;
    #1;
    check($sformatf("v%0d o_ready", idx), 32'(ordy), 32'(v.e_rdy));
    if (v.e_rdy != 4'b0000) begin
      ch = 0;
      for (int g = 0; g < W; g++) if (v.e_rdy[g]) ch = g;
      e.d = v.d[ch];
      e.s = 2'(ch);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (v.rst) begin
      exp_word = 8'h00;
      exp_sel  = 2'd0;
    end else if (sb_q.size() > 0) begin
      e        = sb_q.pop_front();
      exp_word = e.d;
      exp_sel  = e.s;
    end
    check($sformatf("v%0d o_valid", idx), 32'(ov), 32'(v.e_ov));
    check($sformatf("v%0d o_output", idx), 32'(dout), 32'(exp_word));
    check($sformatf("v%0d o_select", idx), 32'(sel), 32'(exp_sel));
  endtask

  initial begin
    reset = 1'b1; vld = 4'b0000; rdy = 1'b0; din = '0;
    exp_word = 8'h00; exp_sel = 2'd0;

    // Reset held two cycles with everything requesting
    tbl.push_back(mk(1'b1, 4'b1111, 1'b1, 8'h12, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1111, 1'b1, 8'h12, 4'b0000, 1'b0));
    // Single channel 2
    tbl.push_back(mk(1'b0, 4'b0100, 1'b1, 8'hA5, 4'b0100, 1'b1));
    // Reset pointer, then all channels for six cycles
    tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 8'h12, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 8'h12, 4'b0001, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 8'h12, 4'b0010, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 8'h12, 4'b0100, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 8'h12, 4'b1000, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 8'h12, 4'b0001, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 8'h12, 4'b0010, 1'b1));
    // Backpressure: load 3C, stall three cycles, then release
    tbl.push_back(mk(1'b0, 4'b0100, 1'b1, 8'h3C, 4'b0100, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b0, 8'h12, 4'b0000, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b0, 8'h12, 4'b0000, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b0, 8'h12, 4'b0000, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 8'h12, 4'b1000, 1'b1));
    // Wrap-around after channel 3 with channels 0 and 3 requesting
    tbl.push_back(mk(1'b0, 4'b1001, 1'b1, 8'h12, 4'b0001, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1001, 1'b1, 8'h12, 4'b1000, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1001, 1'b1, 8'h12, 4'b0001, 1'b1));
    // Idle load empties the register but keeps word and select
    tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 8'h12, 4'b0000, 1'b0));
    // Reset mid-operation while stalled
    tbl.push_back(mk(1'b0, 4'b0100, 1'b1, 8'h5A, 4'b0100, 1'b1));
    tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 8'h12, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 8'h12, 4'b0001, 1'b1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Hand-written: stall a held word, then drain it with no new request
    apply(mk(1'b0, 4'b0000, 1'b0, 8'h12, 4'b0000, 1'b1), 100);
    apply(mk(1'b0, 4'b0000, 1'b0, 8'h12, 4'b0000, 1'b1), 101);
    apply(mk(1'b0, 4'b0000, 1'b1, 8'h12, 4'b0000, 1'b0), 102);
    // Hand-written: pointer sits at 1 after the grant to 0, so channel 1 beats channel 3
    apply(mk(1'b0, 4'b1010, 1'b1, 8'h12, 4'b0010, 1'b1), 103);
    apply(mk(1'b0, 4'b1010, 1'b1, 8'h12, 4'b1000, 1'b1), 104);

    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
